// File: rtl/video_win_pkg.sv
// Shared definitions for the video window flush controller.
// Contents:
//   flush_state_t  - controller FSM states (PASS, GAP, FLUSH)
//   flush_lines_f  - number of flush lines needed for a given window size
//   word_cnt_w_f   - width of the per-line beat counter
//   FLUSH_LINES / WORD_CNT_W - values for the default configuration
//   stream_mark_t  - the four stream markers travelling with a beat
//   stream_beat_t  - one complete beat in the default configuration
package video_win_pkg;

    typedef enum logic [1:0] {
        PASS  = 2'd0,
        GAP   = 2'd1,
        FLUSH = 2'd2
    } flush_state_t;

    localparam int DEF_PX_WIDTH      = 10;
    localparam int DEF_PX_PER_CLK    = 4;
    localparam int DEF_WIN_SIZE      = 5;
    localparam int DEF_MAX_LINE_SIZE = 4112;

    // A window of N lines only releases a line once N/2 newer lines exist.
    function automatic int flush_lines_f(input int win_size);
        return win_size / 2;
    endfunction

    // Counter must hold the longest line in beats, plus the value zero.
    function automatic int word_cnt_w_f(input int max_line_size, input int px_per_clk);
        return $clog2(max_line_size / px_per_clk + 1);
    endfunction

    localparam int FLUSH_LINES = DEF_WIN_SIZE / 2;
    localparam int WORD_CNT_W  = $clog2(DEF_MAX_LINE_SIZE / DEF_PX_PER_CLK + 1);

    typedef struct packed {
        logic line_start;
        logic line_end;
        logic frame_start;
        logic frame_end;
    } stream_mark_t;

    typedef struct packed {
        logic [DEF_PX_PER_CLK*DEF_PX_WIDTH-1:0] data;
        logic [DEF_PX_PER_CLK-1:0]              val;
        stream_mark_t                           mark;
    } stream_beat_t;

endpackage

// File: rtl/flush_line_gen.sv
// Generates one synthetic line of beats.
// A start pulse latches the line length (in beats) and the valid mask of the
// final beat; the line is then produced on consecutive cycles starting the
// cycle after start. Outputs are decoded from the internal registers so they
// are valid during the same cycle the beat counter holds that beat.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   start_i        begin a new line (takes priority over an ongoing one)
//   len_i          line length in beats (nonzero)
//   mask_i         per-pixel valid of the last beat
//   beat_o         a synthetic beat is present this cycle
//   val_o          per-pixel valid of the current beat
//   line_start_o   current beat is the first of the line
//   line_end_o     current beat is the last of the line
//   done_o         line completes with this beat
module flush_line_gen
    import video_win_pkg::*;
#(
    parameter int PX_PER_CLK = 4,
    parameter int WCW        = 11
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [WCW-1:0]        len_i,
    input  logic [PX_PER_CLK-1:0] mask_i,
    output logic                  beat_o,
    output logic [PX_PER_CLK-1:0] val_o,
    output logic                  line_start_o,
    output logic                  line_end_o,
    output logic                  done_o
);

    localparam logic [WCW-1:0] CNT_ONE = WCW'(1'b1);

    logic                  r_busy;
    logic [WCW-1:0]        r_idx;
    logic [WCW-1:0]        r_len;
    logic [PX_PER_CLK-1:0] r_mask;
    logic                  w_last;

    assign w_last       = r_busy & (r_idx == r_len);
    assign beat_o       = r_busy;
    assign val_o        = w_last ? r_mask : {PX_PER_CLK{1'b1}};
    assign line_start_o = r_busy & (r_idx == CNT_ONE);
    assign line_end_o   = w_last;
    assign done_o       = w_last;

    // Beat counter: load on start, advance while busy, stop after last beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_busy <= 1'b0;
            r_idx  <= '0;
            r_len  <= '0;
            r_mask <= {PX_PER_CLK{1'b1}};
        end else if (start_i) begin
            r_busy <= 1'b1;
            r_idx  <= CNT_ONE;
            r_len  <= len_i;
            r_mask <= mask_i;
        end else if (r_busy) begin
            if (w_last) begin
                r_busy <= 1'b0;
            end else begin
                r_idx <= r_idx + CNT_ONE;
            end
        end else begin
            r_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/video_window_flush_ctrl.sv
// Pass-through stage in front of a sliding-window generator that appends
// WIN_SIZE/2 synthetic flush lines after every frame so the generator can
// release the last real lines of the frame.
// The last real line's geometry (beats and final-beat valid mask) is measured
// in PASS and replayed for each flush line; the frame_end marker is moved from
// the last real beat to the last flush beat. While flushing the source is held
// off with ready_o=0; beats presented anyway are dropped and flagged.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   px_data_i, px_data_val_i     input pixels and per-pixel valid
//   line/frame start/end _i      input stream markers
//   ready_o                      source may present beats
//   px_data_o, px_data_val_o     output pixels and per-pixel valid
//   line/frame start/end _o      output stream markers
//   flush_active_o               controller is in GAP or FLUSH
//   drop_err_o                   a beat was discarded last cycle
module video_window_flush_ctrl
    import video_win_pkg::*;
#(
    parameter int PX_WIDTH      = 10,
    parameter int PX_PER_CLK    = 4,
    parameter int WIN_SIZE      = 5,
    parameter int MAX_LINE_SIZE = 4112,
    parameter int GAP_CYCLES    = 2,
    parameter int FILL_VALUE    = 0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [PX_PER_CLK*PX_WIDTH-1:0] px_data_i,
    input  logic [PX_PER_CLK-1:0]          px_data_val_i,
    input  logic                           line_start_i,
    input  logic                           line_end_i,
    input  logic                           frame_start_i,
    input  logic                           frame_end_i,
    output logic                           ready_o,
    output logic [PX_PER_CLK*PX_WIDTH-1:0] px_data_o,
    output logic [PX_PER_CLK-1:0]          px_data_val_o,
    output logic                           line_start_o,
    output logic                           line_end_o,
    output logic                           frame_start_o,
    output logic                           frame_end_o,
    output logic                           flush_active_o,
    output logic                           drop_err_o
);

    localparam int FL  = flush_lines_f(WIN_SIZE);
    localparam int WCW = word_cnt_w_f(MAX_LINE_SIZE, PX_PER_CLK);
    localparam int LCW = $clog2(FL + 1);
    localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [WCW-1:0] WCNT_ONE = WCW'(1'b1);
    localparam logic [WCW-1:0] WCNT_MAX = {WCW{1'b1}};
    localparam logic [LCW-1:0] LCNT_ONE = LCW'(1'b1);
    localparam logic [LCW-1:0] FL_LAST  = LCW'(FL - 1);
    localparam logic [GCW-1:0] GCNT_ONE = GCW'(1'b1);
    localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_CYCLES - 1);
    localparam logic [PX_WIDTH-1:0]            FILL_PX   = PX_WIDTH'(FILL_VALUE);
    localparam logic [PX_PER_CLK*PX_WIDTH-1:0] FILL_BEAT = {PX_PER_CLK{FILL_PX}};

    function automatic logic [WCW-1:0] sat_inc(input logic [WCW-1:0] v);
        if (v == WCNT_MAX) begin
            return v;
        end else begin
            return v + WCNT_ONE;
        end
    endfunction

    flush_state_t                   r_state;
    logic                           r_ready;
    logic [PX_PER_CLK*PX_WIDTH-1:0] r_data;
    logic [PX_PER_CLK-1:0]          r_val;
    stream_mark_t                   r_mark;
    logic                           r_flush_active;
    logic                           r_drop;
    logic [WCW-1:0]                 r_word_cnt;
    logic [WCW-1:0]                 r_len;
    logic [PX_PER_CLK-1:0]          r_mask;
    logic [LCW-1:0]                 r_line_cnt;
    logic [GCW-1:0]                 r_gap_cnt;

    logic                  w_beat;
    logic                  w_acc;
    logic [WCW-1:0]        w_cnt_incl;
    logic [WCW-1:0]        w_len_next;
    logic [PX_PER_CLK-1:0] w_mask_next;
    logic                  w_len_nz;
    logic                  w_gen_start;
    logic                  w_gen_beat;
    logic [PX_PER_CLK-1:0] w_gen_val;
    logic                  w_gen_ls;
    logic                  w_gen_le;
    logic                  w_gen_done;

    // Only PASS ever raises ready, so an accepted beat implies PASS.
    assign w_beat      = |px_data_val_i;
    assign w_acc       = w_beat & r_ready;
    assign w_cnt_incl  = line_start_i ? WCNT_ONE : sat_inc(r_word_cnt);
    // Geometry including the current beat, so a beat carrying both line_end
    // and frame_end flushes with the length it just completed.
    assign w_len_next  = (w_acc & line_end_i) ? w_cnt_incl : r_len;
    assign w_mask_next = (w_acc & line_end_i) ? px_data_val_i : r_mask;
    assign w_len_nz    = |w_len_next;

    // Start a flush line in the cycle the FSM moves into FLUSH.
    always_comb begin
        w_gen_start = 1'b0;
        case (r_state)
            PASS: begin
                if (GAP_CYCLES == 0) begin
                    w_gen_start = w_acc & frame_end_i & w_len_nz;
                end else begin
                    w_gen_start = 1'b0;
                end
            end
            GAP: begin
                w_gen_start = (r_gap_cnt == GAP_LAST);
            end
            FLUSH: begin
                if (GAP_CYCLES == 0) begin
                    w_gen_start = w_gen_done & (r_line_cnt != FL_LAST);
                end else begin
                    w_gen_start = 1'b0;
                end
            end
            default: begin
                w_gen_start = 1'b0;
            end
        endcase
    end

    flush_line_gen #(
        .PX_PER_CLK (PX_PER_CLK),
        .WCW        (WCW)
    ) u_line_gen (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (w_gen_start),
        .len_i        (w_len_next),
        .mask_i       (w_mask_next),
        .beat_o       (w_gen_beat),
        .val_o        (w_gen_val),
        .line_start_o (w_gen_ls),
        .line_end_o   (w_gen_le),
        .done_o       (w_gen_done)
    );

    // Controller FSM with line measurement and registered stream outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state        <= PASS;
            r_ready        <= 1'b1;
            r_data         <= '0;
            r_val          <= '0;
            r_mark         <= '0;
            r_flush_active <= 1'b0;
            r_drop         <= 1'b0;
            r_word_cnt     <= '0;
            r_len          <= '0;
            r_mask         <= {PX_PER_CLK{1'b1}};
            r_line_cnt     <= '0;
            r_gap_cnt      <= '0;
        end else begin
            r_drop <= w_beat & ~r_ready;
            r_len  <= w_len_next;
            r_mask <= w_mask_next;
            if (w_acc) begin
                r_word_cnt <= w_cnt_incl;
            end
            // Idle beat unless a state below overrides it.
            r_data <= '0;
            r_val  <= '0;
            r_mark <= '0;

            case (r_state)
                PASS: begin
                    r_ready        <= 1'b1;
                    r_flush_active <= 1'b0;
                    if (w_acc) begin
                        r_data                <= px_data_i;
                        r_val                 <= px_data_val_i;
                        r_mark.line_start     <= line_start_i;
                        r_mark.line_end       <= line_end_i;
                        r_mark.frame_start    <= frame_start_i;
                        // frame_end moves to the last flush beat when flushing.
                        r_mark.frame_end      <= frame_end_i & ~w_len_nz;
                        if (frame_end_i && w_len_nz) begin
                            r_ready        <= 1'b0;
                            r_flush_active <= 1'b1;
                            r_gap_cnt      <= '0;
                            r_state        <= (GAP_CYCLES == 0) ? FLUSH : GAP;
                        end
                    end
                end
                GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_gap_cnt <= '0;
                        r_state   <= FLUSH;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GCNT_ONE;
                    end
                end
                FLUSH: begin
                    if (w_gen_beat) begin
                        r_data            <= FILL_BEAT;
                        r_val             <= w_gen_val;
                        r_mark.line_start <= w_gen_ls;
                        r_mark.line_end   <= w_gen_le;
                    end
                    if (w_gen_done) begin
                        if (r_line_cnt == FL_LAST) begin
                            // Ready rises one cycle later, from PASS.
                            r_mark.frame_end <= 1'b1;
                            r_line_cnt       <= '0;
                            r_flush_active   <= 1'b0;
                            r_state          <= PASS;
                        end else begin
                            r_line_cnt <= r_line_cnt + LCNT_ONE;
                            r_gap_cnt  <= '0;
                            r_state    <= (GAP_CYCLES == 0) ? FLUSH : GAP;
                        end
                    end
                end
                default: begin
                    r_state        <= PASS;
                    r_ready        <= 1'b1;
                    r_flush_active <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o        = r_ready;
    assign px_data_o      = r_data;
    assign px_data_val_o  = r_val;
    assign line_start_o   = r_mark.line_start;
    assign line_end_o     = r_mark.line_end;
    assign frame_start_o  = r_mark.frame_start;
    assign frame_end_o    = r_mark.frame_end;
    assign flush_active_o = r_flush_active;
    assign drop_err_o     = r_drop;

endmodule

// File: doc/video_window_flush_ctrl.md
Name: video_window_flush_ctrl

Overview:
- Sits between the video source and the sliding-window generator. Passes the stream through with one register stage.
- The window generator only releases a line once WIN_SIZE/2 newer lines are in its buffers, so the last lines of a frame would otherwise remain stuck.
- At frame end the block holds off the source and injects WIN_SIZE/2 synthetic flush lines. Each flush line has the same geometry as the last real line.
- The last flush line carries frame_end, so the generator emits every real line of the frame.

Parameters:
- PX_WIDTH, 10, bits per pixel
- PX_PER_CLK, 4, pixels per beat
- WIN_SIZE, 5, window size of the downstream generator (odd, >=3); FLUSH_LINES = WIN_SIZE/2
- MAX_LINE_SIZE, 4112, maximum pixels per line
- GAP_CYCLES, 2, idle cycles inserted before each flush line
- FILL_VALUE, 0, pixel value of flush pixels

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- px_data_i  in  PX_PER_CLK*PX_WIDTH  input pixels
- px_data_val_i  in  PX_PER_CLK  per-pixel valid; a beat exists when any bit is set
- line_start_i / line_end_i / frame_start_i / frame_end_i  in  1 each  stream markers, qualified by a beat
- ready_o  out  1  source may present beats
- px_data_o  out  PX_PER_CLK*PX_WIDTH  pixels to the window generator
- px_data_val_o  out  PX_PER_CLK  per-pixel valid
- line_start_o / line_end_o / frame_start_o / frame_end_o  out  1 each  stream markers
- flush_active_o  out  1  high while the FSM is in GAP or FLUSH
- drop_err_o  out  1  one-cycle pulse when a beat arrives while ready_o=0 (the beat is discarded)

Behaviour:
- Reset values:
  - all outputs 0 except ready_o=1
  - FSM in PASS
  - stored length = 0, stored mask = all ones
- Word counter width: $clog2(MAX_LINE_SIZE/PX_PER_CLK+1).
- PASS:
  - Input beats are registered to the outputs with 1-cycle latency; data, valid and markers are unchanged.
  - An exception applies to frame_end (see transition below).
  - Non-beat cycles output val=0 and all markers 0.
- Line measurement (PASS only):
  - The word counter resets to 1 on a beat with line_start_i and increments on every other beat.
  - On a beat with line_end_i, the stored length is latched as the counter value, including that beat. The stored mask is latched as that beat's px_data_val_i.
  - A beat with line_start_i and line_end_i together stores length 1.
  - The counter saturates at its maximum.
- PASS -> GAP transition:
  - Occurs on an accepted beat with frame_end_i=1 when the resulting stored length is nonzero.
  - That beat is output with frame_end_o forced to 0; line_end_o is kept.
  - ready_o drops in the same cycle the registered beat appears on the outputs.
- Frame end with no measured line: if stored length = 0, frame_end passes through unchanged and the FSM stays in PASS.
- GAP:
  - Counts GAP_CYCLES cycles with val_o=0, then goes to FLUSH.
  - With GAP_CYCLES=0, FLUSH starts in the cycle after the frame_end beat is output.
- FLUSH: emits stored-length beats on consecutive cycles, one flush line per visit.
  - Data: every pixel = FILL_VALUE.
  - Valid: all ones on every beat except the last, which uses the stored mask.
  - line_start_o on beat 1 and line_end_o on the last beat.
  - frame_start_o is never asserted during a flush.
  - At the end of the line the flush-line counter increments. If it is below FLUSH_LINES, the FSM returns to GAP.
  - Otherwise frame_end_o is asserted on that last beat, the FSM returns to PASS, ready_o=1 from the next cycle, and the flush counter clears.
- Drops: a beat presented while ready_o=0 is discarded with a drop_err_o pulse. It does not affect measurement or state.
- Source contract: the source must hold data while ready_o=0.
- Stored length persists across frames; the next frame's lines overwrite it.
- Reset mid-flush: immediate return to the reset state. No frame_end_o is emitted for the aborted frame.
- Total flush beats per frame = FLUSH_LINES*len.
- Added input stall per frame = FLUSH_LINES*(len+GAP_CYCLES) + 1 cycles.

Decomposition:
- Shared package video_win_pkg:
  - FSM state enum (PASS, GAP, FLUSH)
  - localparams FLUSH_LINES and WORD_CNT_W
  - packed stream-beat struct (data, val, four markers)
- One sub-module, flush_line_gen:
  - takes start, length and mask
  - produces one synthetic line of beats with a done pulse
  - contains the beat counter and the marker generation

Test Plan:
- Nominal flush (WIN_SIZE=5, PX_PER_CLK=4): 3 lines of 16 px -> frame_end_o absent on real line 3.
  - 2 gap cycles precede each of the 2 flush lines (len 4 words, val 4'hF, data 0).
  - frame_end_o on the 8th flush beat; ready_o returns high 1 cycle later.
- Partial last word: lines of 14 px -> flush lines are 4 beats, last beat val 4'b0011, line_end_o on it.
- Drop: drive a beat while flush_active_o=1 -> drop_err_o pulses for 1 cycle; output count is unchanged (8 flush beats).
- Zero-length: frame_end on the first beat after reset, without a prior line_end -> frame_end_o passes through; no flush, ready_o stays 1.
- Reset mid-flush: assert rst_i during the 2nd flush beat -> all outputs 0, ready_o=1. The next frame of 2 lines x 8 px flushes with length 2.
- Back-to-back frames with GAP_CYCLES=0 (WIN_SIZE=3): 1 flush line starts the cycle after the frame_end beat. A new frame_start accepted after ready_o rises passes with 1-cycle latency.
